word_break_tx: RTL and testbench

- Transmit-side counterpart to the byte-to-word joiner: accepts wide words and serialises them into narrow bytes, MSB byte first.
- Byte order matches the joiner's fill order: the first byte sent lands in [31:24], the last in [7:0].
- Sits between a word-producing block and a byte link feeding the joiner.
- Contains a small word FIFO so upstream can run ahead while bytes drain under downstream backpressure.

---
 rtl/word_break_tx_if.sv | 34 +++
 rtl/word_break_tx.sv | 153 +++++++++++++++
 tb/tb_word_break_tx.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/word_break_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : word_break_tx_if
//  Description : Word-in / byte-out handshake bundle for word_break_tx.
//                The slave modport is the serialiser. The master modport is
//                the surrounding logic, which acts as both the word producer
//                and the byte consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface word_break_tx_if #(
  parameter int WORD_IN_SIZE  = 32,
  parameter int WORD_OUT_SIZE = 8,
  parameter int FIFO_DEPTH    = 2
);
  logic [WORD_IN_SIZE-1:0]       word_in;
  logic                          valid_in;
  logic                          ready_out;
  logic [WORD_OUT_SIZE-1:0]      data_out;
  logic                          valid_out;
  logic                          ready_in;
  logic                          last_o;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport master (
    output word_in, valid_in, ready_in,
    input  ready_out, data_out, valid_out, last_o, fifo_count
  );

  modport slave (
    input  word_in, valid_in, ready_in,
    output ready_out, data_out, valid_out, last_o, fifo_count
  );
endinterface
`default_nettype wire

// File: rtl/word_break_tx.sv
`default_nettype none
// ============================================================================
//  Module      : word_break_tx
//  Description : Serialises wide words into narrow bytes, most significant
//                byte first. A small word FIFO lets the upstream producer run
//                ahead while the byte link stalls under backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_break_tx #(
  parameter int WORD_IN_SIZE  = 32,
  parameter int WORD_OUT_SIZE = 8,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  word_break_tx_if.slave        bus
);

  // Number of bytes in each word, and the widths derived from it
  localparam int c_N       = WORD_IN_SIZE / WORD_OUT_SIZE;
  localparam int c_CNT_W   = (c_N > 1) ? $clog2(c_N) : 1;
  localparam int c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_FC_W    = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(c_N - 1);
  localparam logic [c_FC_W-1:0]  c_FULL     = c_FC_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;

  logic [WORD_IN_SIZE-1:0]   r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]        r_wr_ptr;
  logic [c_PTR_W-1:0]        r_rd_ptr;
  logic [c_FC_W-1:0]         r_count;

  logic [WORD_IN_SIZE-1:0]   r_shift;
  logic [c_CNT_W-1:0]        r_byte_cnt;

  logic                      w_ready;
  logic                      w_push;
  logic                      w_send;
  logic                      w_xfer;
  logic                      w_pop;
  logic                      w_shift;
  logic                      w_fifo_nonempty;
  logic                      w_last_byte;

  // Readiness comes from the registered count only, so a pop in the same
  // cycle never opens a full FIFO for a new word.
  assign w_ready         = (r_count != c_FULL);
  assign w_push          = bus.valid_in && w_ready;
  assign w_send          = (r_state == ST_SEND);
  assign w_xfer          = w_send && bus.ready_in;
  assign w_fifo_nonempty = (r_count != '0);
  assign w_last_byte     = (r_byte_cnt == '0);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus pop/shift strobes; the final byte of a word and the load
  // of the next queued word share one edge, so there is no bubble between words
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fifo_nonempty) begin
          w_pop        = 1'b1;
          w_state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_xfer) begin
          if (!w_last_byte) begin
            w_shift = 1'b1;
          end else if (w_fifo_nonempty) begin
            w_pop = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // FIFO storage; only written on an accepted word, so an undriven word_in
  // while valid_in is low never enters the datapath
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.word_in;
    end
  end

  // FIFO pointers wrap naturally at the power-of-two depth; occupancy tracks
  // push/pop and holds when both happen together
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Shift register and byte counter: load a popped word, or move the next
  // byte up to the top once the current one has been taken
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shift    <= '0;
      r_byte_cnt <= '0;
    end else if (w_pop) begin
      r_shift    <= r_mem[r_rd_ptr];
      r_byte_cnt <= c_LAST_IDX;
    end else if (w_shift) begin
      r_shift    <= {r_shift[WORD_IN_SIZE-WORD_OUT_SIZE-1:0], {WORD_OUT_SIZE{1'b0}}};
      r_byte_cnt <= r_byte_cnt - 1'b1;
    end
  end

  // Byte outputs are forced to zero outside SEND so stale data never leaks
  assign bus.ready_out  = w_ready;
  assign bus.valid_out  = w_send;
  assign bus.data_out   = w_send ? r_shift[WORD_IN_SIZE-1 -: WORD_OUT_SIZE] : '0;
  assign bus.last_o     = w_send && w_last_byte;
  assign bus.fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_word_break_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_word_break_tx
//  Description : Directed vector bench for word_break_tx; per-cycle vectors
//                plus an asynchronous mid-word reset sequence and a byte
//                reassembly scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_word_break_tx;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  word_break_tx_if #(.WORD_IN_SIZE(32), .WORD_OUT_SIZE(8), .FIFO_DEPTH(2)) bus ();

  word_break_tx #(
    .WORD_IN_SIZE  (32),
    .WORD_OUT_SIZE (8),
    .FIFO_DEPTH    (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        vin;
    logic [31:0] win;
    logic        rin;
    logic        push;
    logic        e_rdy;
    logic        e_vld;
    logic [7:0]  e_dat;
    logic        e_last;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  logic [31:0] asm_word;
  int          asm_idx;
  int          n_checks;
  int          n_errors;

  // Append one per-cycle vector; the word is expected to be accepted exactly
  // when it is offered while the block is expected to be ready
  function automatic void add(input logic vin, input logic [31:0] win, input logic rin,
                              input logic e_rdy, input logic e_vld, input logic [7:0] e_dat,
                              input logic e_last, input logic [1:0] e_cnt);
    vec_t v;
    v.vin = vin; v.win = win; v.rin = rin; v.push = vin && e_rdy;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_dat = e_dat; v.e_last = e_last; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Check the outputs of the current cycle, then drive this cycle's inputs
  task automatic step(input int idx);
    vec_t v;
    logic [31:0] w;
    v = vecs[idx];
    @(negedge clock);
    check($sformatf("v%0d ready_out", idx), {31'd0, bus.ready_out}, {31'd0, v.e_rdy});
    check($sformatf("v%0d valid_out", idx), {31'd0, bus.valid_out}, {31'd0, v.e_vld});
    check($sformatf("v%0d data_out", idx), {24'd0, bus.data_out}, {24'd0, v.e_dat});
    check($sformatf("v%0d last_o", idx), {31'd0, bus.last_o}, {31'd0, v.e_last});
    check($sformatf("v%0d fifo_count", idx), {30'd0, bus.fifo_count}, {30'd0, v.e_cnt});
    bus.word_in  = v.win;
    bus.valid_in = v.vin;
    bus.ready_in = v.rin;
    if (v.push) exp_q.push_back(v.win);
    // Reassemble transferred bytes into words, first byte into [31:24]
    if (bus.valid_out === 1'b1 && v.rin) begin
      asm_word = {asm_word[23:0], bus.data_out};
      asm_idx++;
      if (asm_idx == 4) begin
        asm_idx = 0;
        if (exp_q.size() == 0) begin
          check("loopback unexpected word", asm_word, 32'hFFFF_FFFF ^ asm_word);
        end else begin
          w = exp_q.pop_front();
          check($sformatf("loopback word at v%0d", idx), asm_word, w);
        end
      end
    end
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi; i++) step(i);
  endtask

  int s_single, s_b2b, s_bp, s_full, s_rst, s_dead, s_end;

  initial begin
    n_checks = 0; n_errors = 0; asm_idx = 0; asm_word = '0;
    reset = 1'b1;
    bus.word_in = '0; bus.valid_in = 1'b0; bus.ready_in = 1'b0;

    // Single word
    s_single = vecs.size();
    add(1, 32'hA1B2C3D4, 1, 1, 0, 8'h00, 0, 2'd0);
    add(0, 'x,           1, 1, 0, 8'h00, 0, 2'd1);
    add(0, 'x,           1, 1, 1, 8'hA1, 0, 2'd0);
    add(0, 'x,           1, 1, 1, 8'hB2, 0, 2'd0);
    add(0, 'x,           1, 1, 1, 8'hC3, 0, 2'd0);
    add(0, 'x,           1, 1, 1, 8'hD4, 1, 2'd0);
    add(0, 'x,           1, 1, 0, 8'h00, 0, 2'd0);
    // Back-to-back words, no gap between them
    s_b2b = vecs.size();
    add(1, 32'h11223344, 1, 1, 0, 8'h00, 0, 2'd0);
    add(1, 32'h55667788, 1, 1, 0, 8'h00, 0, 2'd1);
    add(1, 32'h99AABBCC, 1, 1, 1, 8'h11, 0, 2'd1);
    add(0, 'x,           1, 0, 1, 8'h22, 0, 2'd2);
    add(0, 'x,           1, 0, 1, 8'h33, 0, 2'd2);
    add(0, 'x,           1, 0, 1, 8'h44, 1, 2'd2);
    add(0, 'x,           1, 1, 1, 8'h55, 0, 2'd1);
    add(0, 'x,           1, 1, 1, 8'h66, 0, 2'd1);
    add(0, 'x,           1, 1, 1, 8'h77, 0, 2'd1);
    add(0, 'x,           1, 1, 1, 8'h88, 1, 2'd1);
    add(0, 'x,           1, 1, 1, 8'h99, 0, 2'd0);
    add(0, 'x,           1, 1, 1, 8'hAA, 0, 2'd0);
    add(0, 'x,           1, 1, 1, 8'hBB, 0, 2'd0);
    add(0, 'x,           1, 1, 1, 8'hCC, 1, 2'd0);
    add(0, 'x,           1, 1, 0, 8'h00, 0, 2'd0);
    // Backpressure while B2 is shown
    s_bp = vecs.size();
    add(1, 32'hA1B2C3D4, 1, 1, 0, 8'h00, 0, 2'd0);
    add(0, 'x,           1, 1, 0, 8'h00, 0, 2'd1);
    add(0, 'x,           1, 1, 1, 8'hA1, 0, 2'd0);
    add(0, 'x,           0, 1, 1, 8'hB2, 0, 2'd0);
    add(0, 'x,           0, 1, 1, 8'hB2, 0, 2'd0);
    add(0, 'x,           0, 1, 1, 8'hB2, 0, 2'd0);
    add(0, 'x,           1, 1, 1, 8'hB2, 0, 2'd0);
    add(0, 'x,           1, 1, 1, 8'hC3, 0, 2'd0);
    add(0, 'x,           1, 1, 1, 8'hD4, 1, 2'd0);
    add(0, 'x,           1, 1, 0, 8'h00, 0, 2'd0);
    // FIFO full: extra word refused, also on the edge where a pop happens
    s_full = vecs.size();
    add(1, 32'h01020304, 0, 1, 0, 8'h00, 0, 2'd0);
    add(1, 32'h05060708, 0, 1, 0, 8'h00, 0, 2'd1);
    add(1, 32'h090A0B0C, 0, 1, 1, 8'h01, 0, 2'd1);
    add(1, 32'hDEADDEAD, 0, 0, 1, 8'h01, 0, 2'd2);
    add(0, 'x,           1, 0, 1, 8'h01, 0, 2'd2);
    add(0, 'x,           1, 0, 1, 8'h02, 0, 2'd2);
    add(0, 'x,           1, 0, 1, 8'h03, 0, 2'd2);
    add(1, 32'hDEADDEAD, 1, 0, 1, 8'h04, 1, 2'd2);
    add(0, 'x,           1, 1, 1, 8'h05, 0, 2'd1);
    add(0, 'x,           1, 1, 1, 8'h06, 0, 2'd1);
    add(0, 'x,           1, 1, 1, 8'h07, 0, 2'd1);
    add(0, 'x,           1, 1, 1, 8'h08, 1, 2'd1);
    add(0, 'x,           1, 1, 1, 8'h09, 0, 2'd0);
    add(0, 'x,           1, 1, 1, 8'h0A, 0, 2'd0);
    add(0, 'x,           1, 1, 1, 8'h0B, 0, 2'd0);
    add(0, 'x,           1, 1, 1, 8'h0C, 1, 2'd0);
    add(0, 'x,           1, 1, 0, 8'h00, 0, 2'd0);
    // Lead-in to the mid-word reset: A1 transfers, one word queued
    s_rst = vecs.size();
    add(1, 32'hA1B2C3D4, 1, 1, 0, 8'h00, 0, 2'd0);
    add(1, 32'h5A5A5A5A, 1, 1, 0, 8'h00, 0, 2'd1);
    add(0, 'x,           1, 1, 1, 8'hA1, 0, 2'd1);
    add(0, 'x,           1, 1, 1, 8'hB2, 0, 2'd1);
    // After reset release only DEADBEEF comes out
    s_dead = vecs.size();
    add(1, 32'hDEADBEEF, 1, 1, 0, 8'h00, 0, 2'd0);
    add(0, 'x,           1, 1, 0, 8'h00, 0, 2'd1);
    add(0, 'x,           1, 1, 1, 8'hDE, 0, 2'd0);
    add(0, 'x,           1, 1, 1, 8'hAD, 0, 2'd0);
    add(0, 'x,           1, 1, 1, 8'hBE, 0, 2'd0);
    add(0, 'x,           1, 1, 1, 8'hEF, 1, 2'd0);
    add(0, 'x,           1, 1, 0, 8'h00, 0, 2'd0);
    add(0, 'x,           1, 1, 0, 8'h00, 0, 2'd0);
    s_end = vecs.size();

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset ready_out", {31'd0, bus.ready_out}, 32'd1);
    check("reset valid_out", {31'd0, bus.valid_out}, 32'd0);
    check("reset data_out", {24'd0, bus.data_out}, 32'd0);
    check("reset last_o", {31'd0, bus.last_o}, 32'd0);
    check("reset fifo_count", {30'd0, bus.fifo_count}, 32'd0);
    reset = 1'b0;

    run(s_single, s_rst);
    run(s_rst, s_dead);

    // Asynchronous reset in the middle of a cycle, with B2 showing and a word queued
    #2 reset = 1'b1;
    #1;
    check("async reset valid_out", {31'd0, bus.valid_out}, 32'd0);
    check("async reset fifo_count", {30'd0, bus.fifo_count}, 32'd0);
    check("async reset ready_out", {31'd0, bus.ready_out}, 32'd1);
    check("async reset data_out", {24'd0, bus.data_out}, 32'd0);
    check("async reset last_o", {31'd0, bus.last_o}, 32'd0);
    exp_q.delete();
    asm_idx = 0;
    asm_word = '0;
    bus.valid_in = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    run(s_dead, s_end);

    check("scoreboard drained", exp_q.size(), 32'd0);
    check("no partial word left", asm_idx, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
